// File: rtl/jpeg_pkg.sv
// Shared JPEG decoder definitions: block geometry, YCbCr packing and the
// up-sampler state encoding.
package jpeg_pkg;

    // Block and MCU geometry.
    localparam int BLK_DIM   = 8;
    localparam int MCU_DIM   = 16;
    localparam int PIX_W     = 8;
    localparam int BLK_PIX   = BLK_DIM * BLK_DIM;   // 64 samples per 8x8 block
    localparam int CADDR_W   = 6;                    // address into a 64-entry block
    localparam int CNT_W     = 3;                    // x / y counter width (0..7)

    // Packed YCbCr output word: {Y, Cb, Cr}.
    localparam int Y_LSB     = 16;
    localparam int CB_LSB    = 8;
    localparam int CR_LSB    = 0;
    localparam int OUT_W     = 3 * PIX_W;

    // Up-sampler sequencing: load both chroma blocks, then stream the four Y blocks.
    typedef enum logic {
        LOAD_C   = 1'b0,
        STREAM_Y = 1'b1
    } state_t;

    // Chroma sample covering luma pixel (x, y) of block (bx, by) within the MCU:
    //   (by*4 + y>>1)*8 + (bx*4 + x>>1)
    // Every term is a power of two, so the sum is a plain bit concatenation.
    function automatic logic [CADDR_W-1:0] chroma_addr(
        input logic             by,
        input logic             bx,
        input logic [CNT_W-1:0] y,
        input logic [CNT_W-1:0] x
    );
        return {by, y[2:1], bx, x[2:1]};
    endfunction

endpackage

// File: rtl/chroma_buf.sv
// 64x8 chroma block store: one synchronous write port, one combinational
// read port. Contents survive reset; only the load pointers in the parent
// are cleared.
module chroma_buf
    import jpeg_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [CADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]   wdata,
    input  logic [CADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]   rdata
);

    logic [PIX_W-1:0] mem_q [BLK_PIX];

    // Write one chroma sample per accepted input beat.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/up_sampler.sv
// 4:2:0 chroma up-sampler for one 16x16 MCU. Buffers an 8x8 Cb and Cr block,
// then streams the four Y blocks and emits {Y, Cb, Cr} per pixel, each chroma
// sample covering a 2x2 luma footprint.
//
// Handshakes: every stream uses AXI4-Stream valid/ready. A beat transfers on a
// rising clk edge where tvalid && tready. A source holding tvalid keeps its
// tdata/tlast/tuser stable until the transfer; tready never depends on the
// same port's tvalid.
module up_sampler
    import jpeg_pkg::*;
#(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [PIX_W-1:0] y_axis_tdata,
    input  logic             y_axis_tvalid,
    output logic             y_axis_tready,
    input  logic             y_axis_tlast,
    input  logic             y_axis_tuser,

    input  logic [PIX_W-1:0] cb_axis_tdata,
    input  logic             cb_axis_tvalid,
    output logic             cb_axis_tready,
    input  logic             cb_axis_tlast,
    input  logic             cb_axis_tuser,

    input  logic [PIX_W-1:0] cr_axis_tdata,
    input  logic             cr_axis_tvalid,
    output logic             cr_axis_tready,
    input  logic             cr_axis_tlast,
    input  logic             cr_axis_tuser,

    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,

    output logic             sync_err,
    output state_t           dbg_state
);

    // Image size only travels with the interface; catch nonsense values early.
    if (IMG_WIDTH < MCU_DIM || IMG_HEIGHT < MCU_DIM) begin : g_bad_image_size
        $error("up_sampler: image must be at least one MCU in each dimension");
    end

    localparam logic [CADDR_W-1:0] CNT_LAST = CADDR_W'(BLK_PIX - 1);
    localparam logic [CNT_W-1:0]   XY_LAST  = CNT_W'(BLK_DIM - 1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t             state_q,   state_d;
    logic [CADDR_W-1:0] cb_cnt_q,  cb_cnt_d;
    logic [CADDR_W-1:0] cr_cnt_q,  cr_cnt_d;
    logic               cb_full_q, cb_full_d;
    logic               cr_full_q, cr_full_d;
    logic [CNT_W-1:0]   x_q,       x_d;
    logic [CNT_W-1:0]   y_q,       y_d;
    logic               bx_q,      bx_d;
    logic               by_q,      by_d;
    logic [OUT_W-1:0]   m_data_q,  m_data_d;
    logic               m_valid_q, m_valid_d;
    logic               m_last_q,  m_last_d;
    logic               m_user_q,  m_user_d;
    logic               sync_err_q, sync_err_d;

    // ---------------------------------------------------------------------
    // Handshakes and chroma storage
    // ---------------------------------------------------------------------
    logic               cb_acc, cr_acc, y_acc;
    logic               y_first, y_last, mcu_last;
    logic [CADDR_W-1:0] c_addr;
    logic [PIX_W-1:0]   cb_rd, cr_rd;

    assign cb_axis_tready = (state_q == LOAD_C) && !cb_full_q;
    assign cr_axis_tready = (state_q == LOAD_C) && !cr_full_q;
    assign y_axis_tready  = (state_q == STREAM_Y) && (!m_valid_q || m_axis_tready);

    assign cb_acc = cb_axis_tvalid && cb_axis_tready;
    assign cr_acc = cr_axis_tvalid && cr_axis_tready;
    assign y_acc  = y_axis_tvalid  && y_axis_tready;

    // Position markers of the current Y pixel inside its 8x8 block and the MCU.
    assign y_first  = (x_q == '0) && (y_q == '0);
    assign y_last   = (x_q == XY_LAST) && (y_q == XY_LAST);
    assign mcu_last = y_last && bx_q && by_q;

    assign c_addr = chroma_addr(by_q, bx_q, y_q, x_q);

    chroma_buf u_cb_buf (
        .clk   (clk),
        .we    (cb_acc),
        .waddr (cb_cnt_q),
        .wdata (cb_axis_tdata),
        .raddr (c_addr),
        .rdata (cb_rd)
    );

    chroma_buf u_cr_buf (
        .clk   (clk),
        .we    (cr_acc),
        .waddr (cr_cnt_q),
        .wdata (cr_axis_tdata),
        .raddr (c_addr),
        .rdata (cr_rd)
    );

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // Compute the next value of every register: chroma load, Y raster walk,
    // output stage and framing checks.
    always_comb begin
        state_d    = state_q;
        cb_cnt_d   = cb_cnt_q;
        cr_cnt_d   = cr_cnt_q;
        cb_full_d  = cb_full_q;
        cr_full_d  = cr_full_q;
        x_d        = x_q;
        y_d        = y_q;
        bx_d       = bx_q;
        by_d       = by_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_user_d   = m_user_q;
        sync_err_d = 1'b0;

        // Chroma load: Cb and Cr fill independently; the 64th sample marks full.
        if (cb_acc) begin
            cb_cnt_d = cb_cnt_q + 1'b1;
            if (cb_cnt_q == CNT_LAST) begin
                cb_full_d = 1'b1;
            end
            if ((cb_axis_tuser != (cb_cnt_q == '0)) || (cb_axis_tlast != (cb_cnt_q == CNT_LAST))) begin
                sync_err_d = 1'b1;
            end
        end

        if (cr_acc) begin
            cr_cnt_d = cr_cnt_q + 1'b1;
            if (cr_cnt_q == CNT_LAST) begin
                cr_full_d = 1'b1;
            end
            if ((cr_axis_tuser != (cr_cnt_q == '0)) || (cr_axis_tlast != (cr_cnt_q == CNT_LAST))) begin
                sync_err_d = 1'b1;
            end
        end

        // Y walk: x innermost, then y, then block column, then block row.
        if (y_acc) begin
            if ((y_axis_tuser != y_first) || (y_axis_tlast != y_last)) begin
                sync_err_d = 1'b1;
            end
            x_d = x_q + 1'b1;
            if (x_q == XY_LAST) begin
                y_d = y_q + 1'b1;
                if (y_q == XY_LAST) begin
                    bx_d = ~bx_q;
                    if (bx_q) begin
                        by_d = ~by_q;
                    end
                end
            end
        end

        // Output stage: load on every Y accept, otherwise drain when taken.
        if (y_acc) begin
            m_valid_d                    = 1'b1;
            m_data_d[Y_LSB  +: PIX_W]    = y_axis_tdata;
            m_data_d[CB_LSB +: PIX_W]    = cb_rd;
            m_data_d[CR_LSB +: PIX_W]    = cr_rd;
            m_last_d                     = y_last;
            m_user_d                     = y_first;
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end

        // Sequencing: stream once both chroma blocks are held, reload after the MCU.
        case (state_q)
            LOAD_C: begin
                if (cb_full_q && cr_full_q) begin
                    state_d = STREAM_Y;
                end
            end
            STREAM_Y: begin
                if (y_acc && mcu_last) begin
                    state_d   = LOAD_C;
                    cb_full_d = 1'b0;
                    cr_full_d = 1'b0;
                    cb_cnt_d  = '0;
                    cr_cnt_d  = '0;
                    x_d       = '0;
                    y_d       = '0;
                    bx_d      = 1'b0;
                    by_d      = 1'b0;
                end
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // Register state, counters, output stage and the framing-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_C;
            cb_cnt_q   <= '0;
            cr_cnt_q   <= '0;
            cb_full_q  <= 1'b0;
            cr_full_q  <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            bx_q       <= 1'b0;
            by_q       <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_user_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cb_cnt_q   <= cb_cnt_d;
            cr_cnt_q   <= cr_cnt_d;
            cb_full_q  <= cb_full_d;
            cr_full_q  <= cr_full_d;
            x_q        <= x_d;
            y_q        <= y_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_user_q   <= m_user_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;
    assign sync_err      = sync_err_q;
    assign dbg_state     = state_q;

endmodule
